// File: rtl/debounced_input_bank.sv
// -----------------------------------------------------------------------------
// debounced_input_bank
//
// A bank of CHANNELS independent input conditioners behind a small
// memory-mapped register file. Each channel synchronises its raw input,
// debounces it, and reports debounced press/release edges. Edges that match
// the channel's EDGE_SEL bit latch into a sticky EVENTS flag. irq is the OR
// of the EVENTS flags that are enabled in IRQ_EN.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   din       raw asynchronous inputs, one bit per channel
//   io_addr   register byte offset (0x0 STATE, 0x4 EVENTS, 0x8 EDGE_SEL, 0xC IRQ_EN)
//   io_we     write strobe
//   io_re     read strobe
//   io_wdata  write data
//   io_rdata  registered read data; holds its value while io_re is low
//   level     debounced levels
//   irq       |(EVENTS & IRQ_EN)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// dib_channel: one input channel.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   din_i       raw asynchronous input
//   level_o     debounced level
//   rise_o      high in the cycle before the edge on which level_o goes 0->1
//   fall_o      high in the cycle before the edge on which level_o goes 1->0
// -----------------------------------------------------------------------------
module dib_channel #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // The last synchroniser flop is the level register. It changes on the
        // next edge whenever the stage feeding it differs, so the edge pulses
        // are taken from that comparison to line up with the level change.
        assign level_o = sync;
        assign rise_o  = sync_q[SYNC_STAGES-2] & ~sync;
        assign fall_o  = ~sync_q[SYNC_STAGES-2] & sync;
    end else begin : g_debounce
        localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          toggle;

        // The counter only runs while sync disagrees with level, so any
        // bounce back to the current level restarts the count from zero.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            toggle  = 1'b0;
            if (sync != level_q) begin
                if (cnt_q == LAST) begin
                    level_d = ~level_q;
                    toggle  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_o = level_q;
        assign rise_o  = toggle & ~level_q;
        assign fall_o  = toggle & level_q;
    end

endmodule

module debounced_input_bank #(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic [3:0]          io_addr,
    input  logic                io_we,
    input  logic                io_re,
    input  logic [31:0]         io_wdata,
    output logic [31:0]         io_rdata,
    output logic [CHANNELS-1:0] level,
    output logic                irq
);

    localparam logic [1:0] REG_STATE  = 2'd0;
    localparam logic [1:0] REG_EVENTS = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_IRQEN  = 2'd3;

    logic [CHANNELS-1:0] rise, fall;
    logic [CHANNELS-1:0] ev_set, ev_clr;
    logic [CHANNELS-1:0] events_q, events_d;
    logic [CHANNELS-1:0] edge_sel_q, edge_sel_d;
    logic [CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                aligned;
    logic [CHANNELS-1:0] wbits;
    logic                unused_wdata;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dib_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .din_i   (din[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    // Offsets with non-zero low bits are holes in the map.
    assign aligned      = (io_addr[1:0] == 2'b00);
    assign wbits        = io_wdata[CHANNELS-1:0];
    assign unused_wdata = ^io_wdata;

    always_comb begin
        // EDGE_SEL bit 0 selects rising (press), 1 selects falling (release).
        ev_set     = (rise & ~edge_sel_q) | (fall & edge_sel_q);
        ev_clr     = '0;
        edge_sel_d = edge_sel_q;
        irq_en_d   = irq_en_q;
        if (io_we && aligned) begin
            case (io_addr[3:2])
                REG_EVENTS: ev_clr     = wbits;
                REG_EDGE:   edge_sel_d = wbits;
                REG_IRQEN:  irq_en_d   = wbits;
                default:    ;
            endcase
        end
        // A new event wins over a coincident W1C on the same bit.
        events_d = (events_q & ~ev_clr) | ev_set;
    end

    // Read data is taken from the current flops, so a same-cycle write is
    // not yet visible to the read.
    always_comb begin
        rdata_d = rdata_q;
        if (io_re) begin
            rdata_d = '0;
            if (aligned) begin
                case (io_addr[3:2])
                    REG_STATE:  rdata_d = 32'(level);
                    REG_EVENTS: rdata_d = 32'(events_q);
                    REG_EDGE:   rdata_d = 32'(edge_sel_q);
                    REG_IRQEN:  rdata_d = 32'(irq_en_q);
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_q   <= '0;
            edge_sel_q <= '0;
            irq_en_q   <= '0;
            rdata_q    <= '0;
        end else begin
            events_q   <= events_d;
            edge_sel_q <= edge_sel_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;
    assign irq      = |(events_q & irq_en_q);

endmodule

// File: tb/tb_debounced_input_bank.sv
module tb_debounced_input_bank;
    localparam int CH = 5;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, DEBOUNCE_CYCLES=8
    logic          rst_n;
    logic [CH-1:0] din;
    logic [3:0]    io_addr;
    logic          io_we, io_re;
    logic [31:0]   io_wdata;
    logic [31:0]   io_rdata;
    logic [CH-1:0] level;
    logic          irq;

    // bypass instance, DEBOUNCE_CYCLES=0
    logic          rst0_n;
    logic [CH-1:0] din0;
    logic [31:0]   rdata0;
    logic [CH-1:0] level0;
    logic          irq0;

    int   errs   = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t sb_e;
    logic rd_pend = 1'b0;
    logic [CH-1:0] prev0, nxt0;

    debounced_input_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .io_addr(io_addr), .io_we(io_we),
        .io_re(io_re), .io_wdata(io_wdata), .io_rdata(io_rdata), .level(level), .irq(irq)
    );

    debounced_input_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst0_n), .din(din0), .io_addr(4'h0), .io_we(1'b0),
        .io_re(1'b0), .io_wdata(32'h0), .io_rdata(rdata0), .level(level0), .irq(irq0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        tick();
        io_we    = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        io_addr = a;
        io_re   = 1'b1;
        sb_q.push_back('{tag: tag, val: exp});
        tick();
        io_re   = 1'b0;
    endtask

    task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp,
                          input string tag);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        io_re    = 1'b1;
        sb_q.push_back('{tag: tag, val: exp});
        tick();
        io_we    = 1'b0;
        io_re    = 1'b0;
    endtask

    // read response monitor: a read accepted at a rising edge is compared
    // against the scoreboard on the following falling edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= io_re;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk(sb_e.tag, io_rdata, sb_e.val);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rst0_n = 1'b0;
        din = '0; din0 = '0;
        io_addr = '0; io_we = 1'b0; io_re = 1'b0; io_wdata = '0;
        repeat (2) tick();

        // reset state
        chk("rst_level",  32'(level),  32'h0);
        chk("rst_rdata",  io_rdata,    32'h0);
        chk("rst_irq",    32'(irq),    32'h0);
        chk("rst0_level", 32'(level0), 32'h0);
        chk("rst0_rdata", rdata0,      32'h0);

        // 1: ch0 held high from edge 0, level rises at edge 9
        rst_n = 1'b1; rst0_n = 1'b1;
        din = 5'b00001;
        repeat (9) tick();
        chk("t1_lvl_e8", 32'(level), 32'h0);
        tick();
        chk("t1_lvl_e9", 32'(level), 32'h1);
        chk("t1_irq",    32'(irq),   32'h0);
        bus_rd(4'h4, 32'h1, "t1_events");
        bus_rd(4'h0, 32'h1, "t1_state");
        bus_wr(4'h4, 32'h1);

        // 2: short bounces on ch1 never reach the threshold
        repeat (3) begin
            din[1] = 1'b1;
            repeat (5) tick();
            din[1] = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        chk("t2_level", 32'(level), 32'h1);
        bus_rd(4'h4, 32'h0, "t2_events");

        // 3: ch2 selected for release
        bus_wr(4'h8, 32'h4);
        din[2] = 1'b1;
        repeat (20) tick();
        chk("t3_lvl_pressed", 32'(level), 32'h5);
        bus_rd(4'h4, 32'h0, "t3_no_press_evt");
        din[2] = 1'b0;
        repeat (8) tick();
        chk("t3_lvl_e7", 32'(level), 32'h5);
        bus_rd(4'h4, 32'h0, "t3_evt_e8");
        chk("t3_lvl_e8", 32'(level), 32'h5);
        bus_rd(4'h4, 32'h0, "t3_evt_e9_pre");
        chk("t3_lvl_e9", 32'(level), 32'h1);
        bus_rd(4'h4, 32'h4, "t3_evt_release");
        bus_wr(4'h8, 32'h0);
        bus_rd(4'h4, 32'h4, "t3_sel_keeps_flag");
        bus_rd(4'h8, 32'h0, "t3_edge_sel");
        bus_wr(4'h4, 32'h4);
        bus_rd(4'h4, 32'h0, "t3_cleared");

        // 4: W1C coincident with events
        din[0] = 1'b0;
        repeat (12) tick();
        chk("t4_lvl_rel0", 32'(level), 32'h0);
        din[0] = 1'b1;
        repeat (12) tick();
        chk("t4_lvl_prs0", 32'(level), 32'h1);
        bus_rd(4'h4, 32'h1, "t4_evt0");
        din[3] = 1'b1;
        repeat (9) tick();
        bus_wr(4'h4, 32'h1);
        chk("t4_lvl_ch3", 32'(level), 32'h9);
        bus_rd(4'h4, 32'h8, "t4_clrA_setB");
        bus_wr(4'h4, 32'h8);
        din[0] = 1'b0;
        repeat (12) tick();
        chk("t4_lvl_rel0b", 32'(level), 32'h8);
        din[0] = 1'b1;
        repeat (9) tick();
        bus_wr(4'h4, 32'h1);
        chk("t4_lvl_prs0b", 32'(level), 32'h9);
        bus_rd(4'h4, 32'h1, "t4_set_beats_clr");
        bus_wr(4'h4, 32'h1f);
        bus_rd(4'h4, 32'h0, "t4_clear_all");

        // 5: interrupt and bus decode
        bus_wr(4'hC, 32'hFFFF_FFE2);
        bus_rd(4'hC, 32'h2, "t5_irqen_mask");
        chk("t5_irq_idle", 32'(irq), 32'h0);
        din[1] = 1'b1;
        repeat (9) tick();
        chk("t5_irq_e8", 32'(irq), 32'h0);
        tick();
        chk("t5_irq_e9", 32'(irq),   32'h1);
        chk("t5_lvl",    32'(level), 32'hB);
        bus_wr(4'h4, 32'h2);
        chk("t5_irq_clr", 32'(irq), 32'h0);
        bus_rd(4'h1, 32'h0, "t5_rd_01");
        bus_rd(4'h2, 32'h0, "t5_rd_02");
        bus_rd(4'h3, 32'h0, "t5_rd_03");
        bus_wr(4'h9, 32'hFFFF_FFFF);
        bus_rd(4'h8, 32'h0, "t5_unmapped_wr");
        bus_wr(4'hD, 32'hFFFF_FFFF);
        bus_rd(4'hC, 32'h2, "t5_unmapped_wr2");
        bus_wr(4'h0, 32'h1F);
        bus_rd(4'h0, 32'hB, "t5_state_ro");
        bus_rw(4'hC, 32'h1F, 32'h2, "t5_rw_prewrite");
        bus_rd(4'hC, 32'h1F, "t5_rw_after");
        io_addr = 4'h0;
        repeat (3) tick();
        chk("t5_rdata_hold", io_rdata, 32'h1F);
        chk("t5_irq_none",   32'(irq), 32'h0);

        // reset mid-debounce, inputs held high through release
        din[4] = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst2_level", 32'(level), 32'h0);
        chk("rst2_rdata", io_rdata,   32'h0);
        chk("rst2_irq",   32'(irq),   32'h0);
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        chk("rst2_lvl_e8", 32'(level), 32'h0);
        tick();
        chk("rst2_lvl_e9", 32'(level), 32'h1B);
        bus_rd(4'h4, 32'h1B, "rst2_events");
        bus_rd(4'hC, 32'h0,  "rst2_irqen");

        // 6: bypass instance follows din two edges later
        prev0 = din0;
        for (int n = 0; n < 18; n++) begin
            nxt0 = ((n / 3) % 2 == 1) ? 5'h15 : 5'h0A;
            din0 = nxt0;
            tick();
            chk("t6_level", 32'(level0), 32'(prev0));
            prev0 = nxt0;
        end
        rst0_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level0), 32'h0);
        chk("t6_rst_irq",   32'(irq0),   32'h0);
        chk("t6_rst_rdata", rdata0,      32'h0);

        repeat (2) tick();
        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/debounced_input_bank.md
# debounced_input_bank

- Parametrised input-conditioning peripheral for the I/O system.
- Replaces the per-button fixed debouncer with N independent channels. Each channel has a synchroniser, a configurable debounce counter, and edge detection selectable as press or release.
- Edges are captured in sticky event flags with maskable interrupt.
- Sits between the board buttons/switches and the processor's memory-mapped I/O bus.

## Interface

Parameters:
- CHANNELS, 5, number of input channels, legal 1..32.
- DEBOUNCE_CYCLES, 100000, stable cycles required before a level change is accepted; 0 bypasses debouncing.
- SYNC_STAGES, 2, synchroniser flops per channel, legal 2..4.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, CHANNELS, raw asynchronous inputs.
- io_addr, input, 4, byte offset of register: 0x0, 0x4, 0x8 or 0xC.
- io_we, input, 1, write strobe.
- io_re, input, 1, read strobe.
- io_wdata, input, 32, write data.
- io_rdata, output, 32, registered read data.
- level, output, CHANNELS, debounced levels.
- irq, output, 1, OR of (EVENTS & IRQ_EN).

## Operation

Per channel:
- din passes through SYNC_STAGES flops, giving sync.
- A counter of width $clog2(DEBOUNCE_CYCLES+1) increments every cycle that sync != level.
- The counter clears to 0 whenever sync == level.
- When sync != level and counter == DEBOUNCE_CYCLES-1, level toggles on that edge and the counter clears.
- DEBOUNCE_CYCLES=0: level = sync registered directly, with no counter logic.
- On a level toggle, EVENTS[i] sets if the direction matches EDGE_SEL[i]: 0 = rising (press), 1 = falling (release).

Registers (bits at and above CHANNELS read 0 and ignore writes):
- 0x0 STATE, RO: level.
- 0x4 EVENTS, RW1C: sticky edge flags.
- 0x8 EDGE_SEL, RW.
- 0xC IRQ_EN, RW.

Bus rules:
- Unmapped offsets (io_addr[1:0] != 0) read 0; writes to them are ignored.
- Writes to STATE are ignored.
- Reads have no side effects.
- io_we and io_re are both allowed in the same cycle. The read returns pre-write contents.

Boundary conditions:
- Set beats clear: a W1C write and a new event on the same channel in the same cycle leave the flag set.
- A W1C write on channel A and a new event on channel B in the same cycle: A clears, B sets.
- A bounce shorter than DEBOUNCE_CYCLES leaves level and EVENTS unchanged.
- The counter restarts on every bounce back to the current level.
- Changing EDGE_SEL affects only future toggles. Existing flags are untouched.
- Reset mid-debounce discards progress. An input held high through reset release is debounced as a rising transition and sets EVENTS if EDGE_SEL selects rising.

## Timing

Reset values:
- level, EVENTS, EDGE_SEL, IRQ_EN, io_rdata, irq: all 0.
- Counters and synchroniser flops: 0.

Latency:
- A din change sampled at edge 0 reaches sync at edge SYNC_STAGES-1.
- level toggles at edge SYNC_STAGES-1+DEBOUNCE_CYCLES.
- The EVENTS flag sets on the same edge as the level toggle.
- irq is combinational from EVENTS and IRQ_EN flops: high in the same cycle the flag sets, no extra delay.
- Reads: io_re with io_addr at edge k gives io_rdata valid after edge k. io_rdata holds its value when io_re is low.
- Writes take effect at the edge where io_we is high. The resulting irq change is visible right after that edge.

## Test plan

Parameters CHANNELS=5, DEBOUNCE_CYCLES=8, SYNC_STAGES=2 unless stated.

1. Reset, then din=5'b00001 held from edge 0 -> level[0] rises at edge 9, not before; read EVENTS -> 0x00000001; read STATE -> 0x00000001.
2. din[1] high for 5 cycles then low, repeated 3 times -> level and EVENTS stay 0.
3. Write EDGE_SEL=0x4; press ch2 for 20 cycles, then release -> EVENTS stays 0 after press; EVENTS=0x4 at the debounced release edge.
4. With EVENTS=0x1, write 0x1 to EVENTS in the same cycle ch3's level rises -> EVENTS reads 0x8. Repeat with a ch0 event coincident with its own clear -> EVENTS bit0 remains 1.
5. Write IRQ_EN=0x2; generate a ch1 press -> irq high on the level edge; write EVENTS=0x2 -> irq low after that edge. Reads of 0x1, 0x2, 0x3 return 0.
6. DEBOUNCE_CYCLES=0 instance: din toggles every 3 cycles -> level follows with exactly 2-cycle latency. Assert rst_n low mid-sequence -> all outputs 0 immediately (asynchronously).
